regular_param: RTL and testbench



---
 rtl/regular_param.sv | 217 +++++++++++++++++++++
 tb/tb_regular_param.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/regular_param.sv
// JPEG-LS regular-mode error coder: bias correction, modular error, A/B/C/N update, Golomb-Rice code fields.
// Latency 11 cycles accept->o_vl, one pixel/cycle; o_rdy drops during context clear and pre-clear drain.
module regular_param #(
    parameter int BPP   = 8,
    parameter int NCTX  = 365,
    parameter int QW    = 9,
    parameter int RESET = 64,
    parameter int LIMIT = 2 * (BPP + ((BPP > 8) ? BPP : 8)),
    localparam int MAXUN = LIMIT - BPP - 1,
    localparam int ZW    = $clog2(MAXUN + 2)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_clr,
    output logic           o_rdy,
    input  logic           i_vl,
    input  logic [BPP-1:0] i_x,
    input  logic [BPP-1:0] i_px,
    input  logic           i_s,
    input  logic [QW-1:0]  i_qh,
    output logic           o_vl,
    output logic [ZW-1:0]  o_zc,
    output logic [BPP-1:0] o_bv,
    output logic [4:0]     o_bc
);
    localparam int RANGE  = 1 << BPP;
    localparam int MAXVAL = RANGE - 1;
    localparam int NW     = $clog2(RESET) + 1;
    localparam int AW     = BPP + NW + 1;
    localparam int BW     = NW + 1;
    localparam int LAT    = 11;
    localparam int A_RAW  = (RANGE + 32) / 64;
    localparam int A_INIT = (A_RAW > 2) ? A_RAW : 2;

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_DRAIN} state_t;

    typedef struct packed {
        logic [ZW-1:0]  zc;
        logic [BPP-1:0] bv;
        logic [4:0]     bc;
    } out_t;

    state_t          state_q, state_d;
    logic [QW-1:0]   addr_q, addr_d;
    logic [LAT-1:0]  vld_q, vld_d;
    logic [BPP-1:0]  x_q, x_d, px_q, px_d;
    logic            s_q, s_d;
    logic [QW-1:0]   qh_q, qh_d;
    out_t            pipe_q [LAT-1];
    out_t            pipe_d [LAT-1];

    logic [AW-1:0]        ctx_a_q [NCTX];
    logic signed [BW-1:0] ctx_b_q [NCTX];
    logic signed [7:0]    ctx_c_q [NCTX];
    logic [NW-1:0]        ctx_n_q [NCTX];

    logic                 accept, init_we, mem_we;
    logic [QW-1:0]        mem_addr;
    logic [AW-1:0]        wr_a;
    logic signed [BW-1:0] wr_b;
    logic signed [7:0]    wr_c;
    logic [NW-1:0]        wr_n;

    int   a_i, b_i, c_i, n_i, pxc, err, abs_err, k, merr, quo;
    int   a_n, b_n, c_n, n_n;
    out_t res;

    assign accept = i_vl && (state_q == ST_RUN);

    always_comb begin : fsm
        state_d = state_q;
        addr_d  = addr_q;
        o_rdy   = 1'b0;
        init_we = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_we = 1'b1;
                if (addr_q == QW'(NCTX - 1)) begin
                    state_d = ST_RUN;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + QW'(1);
                end
            end
            ST_RUN: begin
                o_rdy = 1'b1;
                if (i_clr) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (vld_q == '0) begin
                    state_d = ST_INIT;
                    addr_d  = '0;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Read, code and write back the context in one stage so a pixel always sees its predecessor's update.
    always_comb begin : datapath
        a_i = int'(ctx_a_q[qh_q]);
        b_i = int'(ctx_b_q[qh_q]);
        c_i = int'(ctx_c_q[qh_q]);
        n_i = int'(ctx_n_q[qh_q]);

        pxc = int'(px_q) + (s_q ? -c_i : c_i);
        if (pxc < 0) pxc = 0;
        else if (pxc > MAXVAL) pxc = MAXVAL;
        err = s_q ? (pxc - int'(x_q)) : (int'(x_q) - pxc);
        if (err < 0) err = err + RANGE;
        if (err >= RANGE / 2) err = err - RANGE;
        abs_err = (err < 0) ? -err : err;

        k = AW;
        for (int i = AW; i >= 0; i--) begin
            if ((longint'(n_i) << i) >= longint'(a_i)) k = i;
        end

        if (k == 0 && 2 * b_i <= -n_i) merr = (err >= 0) ? 2 * err + 1 : -2 * (err + 1);
        else                           merr = (err >= 0) ? 2 * err : -2 * err - 1;
        quo = merr >> k;

        res = '0;
        if (quo < MAXUN) begin
            res.zc = ZW'(quo + 1);
            res.bv = BPP'(merr);
            res.bc = 5'(k);
        end else begin
            res.zc = ZW'(MAXUN + 1);
            res.bv = BPP'(merr - 1);
            res.bc = 5'(BPP);
        end

        a_n = a_i + abs_err;
        b_n = b_i + err;
        n_n = n_i;
        if (n_i == RESET) begin
            a_n = a_n >>> 1;
            b_n = b_n >>> 1;
            n_n = n_n >>> 1;
        end
        n_n = n_n + 1;
        c_n = c_i;
        if (b_n <= -n_n) begin
            b_n = b_n + n_n;
            if (b_n <= -n_n) b_n = -n_n + 1;
            if (c_n > -128) c_n = c_n - 1;
        end else if (b_n > 0) begin
            b_n = b_n - n_n;
            if (b_n > 0) b_n = 0;
            if (c_n < 127) c_n = c_n + 1;
        end
    end

    always_comb begin : mem_wr
        mem_we   = init_we | vld_q[0];
        mem_addr = init_we ? addr_q : qh_q;
        if (init_we) begin
            wr_a = AW'(A_INIT);
            wr_b = '0;
            wr_c = '0;
            wr_n = NW'(1);
        end else begin
            wr_a = AW'(a_n);
            wr_b = BW'(b_n);
            wr_c = 8'(c_n);
            wr_n = NW'(n_n);
        end
    end

    always_comb begin : pipe_next
        vld_d     = {vld_q[LAT-2:0], accept};
        x_d       = i_x;
        px_d      = i_px;
        s_d       = i_s;
        qh_d      = i_qh;
        pipe_d[0] = res;
        for (int i = 1; i < LAT - 1; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            ctx_a_q[mem_addr] <= wr_a;
            ctx_b_q[mem_addr] <= wr_b;
            ctx_c_q[mem_addr] <= wr_c;
            ctx_n_q[mem_addr] <= wr_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            addr_q  <= '0;
            vld_q   <= '0;
            x_q     <= '0;
            px_q    <= '0;
            s_q     <= 1'b0;
            qh_q    <= '0;
            pipe_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            vld_q   <= vld_d;
            x_q     <= x_d;
            px_q    <= px_d;
            s_q     <= s_d;
            qh_q    <= qh_d;
            pipe_q  <= pipe_d;
        end
    end

    assign o_vl = vld_q[LAT-1];
    assign o_zc = o_vl ? pipe_q[LAT-2].zc : '0;
    assign o_bv = o_vl ? pipe_q[LAT-2].bv : '0;
    assign o_bc = o_vl ? pipe_q[LAT-2].bc : '0;

endmodule

// File: tb/tb_regular_param.sv
// Randomised scoreboard bench for regular_param (BPP=8, NCTX=28, RESET=64) against a sequential JPEG-LS model.
module tb_regular_param;
    localparam int BPP    = 8;
    localparam int NCTX   = 28;
    localparam int QW     = 5;
    localparam int RST    = 64;
    localparam int RANGE  = 1 << BPP;
    localparam int MAXVAL = RANGE - 1;
    localparam int MAXUN  = 2 * (BPP + 8) - BPP - 1;
    localparam int ZW     = 5;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           i_clr = 1'b0;
    logic           o_rdy;
    logic           i_vl = 1'b0;
    logic [BPP-1:0] i_x = '0;
    logic [BPP-1:0] i_px = '0;
    logic           i_s = 1'b0;
    logic [QW-1:0]  i_qh = '0;
    logic           o_vl;
    logic [ZW-1:0]  o_zc;
    logic [BPP-1:0] o_bv;
    logic [4:0]     o_bc;

    regular_param #(.BPP(BPP), .NCTX(NCTX), .QW(QW), .RESET(RST)) dut (
        .clk(clk), .rst_n(rst_n), .i_clr(i_clr), .o_rdy(o_rdy),
        .i_vl(i_vl), .i_x(i_x), .i_px(i_px), .i_s(i_s), .i_qh(i_qh),
        .o_vl(o_vl), .o_zc(o_zc), .o_bv(o_bv), .o_bc(o_bc)
    );

    always #5 clk = ~clk;

    typedef struct { int zc; int bv; int bc; int cyc; } exp_t;
    exp_t exp_q[$];

    int checks = 0, passes = 0, stray = 0, cyc = 0;
    int m_n[NCTX], m_a[NCTX], m_b[NCTX], m_c[NCTX];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic model_init();
        int ai = (RANGE + 32) / 64;
        if (ai < 2) ai = 2;
        for (int i = 0; i < NCTX; i++) begin
            m_n[i] = 1; m_a[i] = ai; m_b[i] = 0; m_c[i] = 0;
        end
    endtask

    // Sequential reference: one pixel coded from, then folded into, its context statistics.
    task automatic model_px(input int x, input int px, input int s, input int q,
                            output int zc, output int bv, output int bc);
        int pxc, e, k, merr, n;
        pxc = s ? px - m_c[q] : px + m_c[q];
        pxc = (pxc < 0) ? 0 : ((pxc > MAXVAL) ? MAXVAL : pxc);
        e = s ? pxc - x : x - pxc;
        e = ((e % RANGE) + RANGE) % RANGE;
        if (e >= RANGE / 2) e -= RANGE;
        k = 0;
        while ((m_n[q] << k) < m_a[q]) k++;
        if (k == 0 && 2 * m_b[q] <= -m_n[q]) merr = (e >= 0) ? 2 * e + 1 : -2 * (e + 1);
        else merr = (e >= 0) ? 2 * e : -2 * e - 1;
        if ((merr >> k) < MAXUN) begin
            zc = (merr >> k) + 1; bv = merr; bc = k;
        end else begin
            zc = MAXUN + 1; bv = merr - 1; bc = BPP;
        end
        m_a[q] += (e < 0) ? -e : e;
        m_b[q] += e;
        n = m_n[q];
        if (n == RST) begin
            m_a[q] = m_a[q] / 2;
            m_b[q] = (m_b[q] >= 0) ? m_b[q] / 2 : -((-m_b[q] + 1) / 2);
            n = n / 2;
        end
        n = n + 1;
        m_n[q] = n;
        if (m_b[q] <= -n) begin
            m_b[q] = (m_b[q] + n <= -n) ? -n + 1 : m_b[q] + n;
            if (m_c[q] != -128) m_c[q]--;
        end else if (m_b[q] > 0) begin
            m_b[q] = (m_b[q] - n > 0) ? 0 : m_b[q] - n;
            if (m_c[q] != 127) m_c[q]++;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (o_vl) begin
            if (exp_q.size() == 0) begin
                checks++;
                stray++;
                $display("FAIL stray_output: got zc=%0d bv=%0d bc=%0d, expected no output", o_zc, o_bv, o_bc);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (int'(o_zc) == e.zc && int'(o_bv) == e.bv && int'(o_bc) == e.bc) passes++;
                else $display("FAIL out: got zc=%0d bv=%0d bc=%0d, expected zc=%0d bv=%0d bc=%0d",
                              o_zc, o_bv, o_bc, e.zc, e.bv, e.bc);
                chk("latency", cyc - e.cyc, 11);
            end
        end
    end

    task automatic send(input int x, input int px, input int s, input int q,
                        input bit fixed, input int fzc, input int fbv, input int fbc);
        int n = 0;
        exp_t e;
        while (!o_rdy && n < 300) begin @(negedge clk); n++; end
        if (!o_rdy) begin
            checks++;
            $display("FAIL rdy_wait: got o_rdy=0 after %0d cycles, expected 1", n);
            return;
        end
        i_vl = 1'b1; i_x = 8'(x); i_px = 8'(px); i_s = 1'(s); i_qh = 5'(q);
        model_px(x, px, s, q, e.zc, e.bv, e.bc);
        if (fixed) begin e.zc = fzc; e.bv = fbv; e.bc = fbc; end
        e.cyc = cyc;
        exp_q.push_back(e);
        @(negedge clk);
        i_vl = 1'b0;
    endtask

    task automatic do_reset(input int hold);
        @(negedge clk);
        rst_n = 1'b0; i_vl = 1'b0; i_clr = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        model_init();
        repeat (hold) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_init();
        int n = 0;
        bit quiet = 1'b1;
        chk("init_start_outputs", int'({o_rdy, o_vl, o_zc, o_bv, o_bc}), 0);
        while (!o_rdy && n < 100) begin
            @(negedge clk);
            n++;
            if (!o_rdy && (o_vl || o_zc != 0 || o_bv != 0 || o_bc != 0)) quiet = 1'b0;
        end
        chk("init_cycles", n, NCTX);
        chk("init_quiet", int'(quiet), 1);
    endtask

    task automatic wait_empty();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
        chk("pending_outputs", exp_q.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, g;
        model_init();
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({o_rdy, o_vl, o_zc, o_bv, o_bc}), 0);
        rst_n = 1'b1;
        check_init();

        send(100, 98, 0, 3, 1'b1, 2, 4, 2);
        send(50, 60, 1, 5, 1'b1, 6, 20, 2);
        send(100, 0, 0, 7, 1'b1, 24, 199, 8);
        wait_empty();

        // ctx 0: drive C toward -128 and N through the halving threshold with random gaps
        for (int i = 0; i < 200; i++) begin
            if (i < 140) send(0, 128, 0, 0, 1'b0, 0, 0, 0);
            else         send(int'($urandom_range(0, 2)), 132, 0, 0, 1'b0, 0, 0, 0);
            g = int'($urandom_range(0, 12));
            if ($urandom_range(0, 2) == 0) g = 0;
            repeat (g) @(negedge clk);
        end
        wait_empty();

        for (int i = 0; i < 11; i++) begin
            if (i == 10) i_clr = 1'b1;
            send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0, 0, 0, 0);
        end
        model_init();
        n = 0;
        while (!o_rdy && n < 200) begin
            i_vl = 1'b1; i_clr = 1'b1; i_x = 8'($urandom); i_qh = 5'($urandom_range(0, 27));
            @(negedge clk);
            n++;
        end
        i_vl = 1'b0; i_clr = 1'b0;
        chk("clr_drained", exp_q.size(), 0);
        chk("clr_rdy_low_cycles_in_range", int'(n >= NCTX + 11 && n <= NCTX + 12), 1);
        send(100, 98, 0, 3, 1'b1, 2, 4, 2);
        wait_empty();

        do_reset(2);
        repeat (10) @(negedge clk);
        do_reset(2);
        check_init();

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                do_reset(3);
                check_init();
                chk("no_stray_after_reset", stray, 0);
            end
            send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 1)),
                 ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, NCTX - 1)),
                 1'b0, 0, 0, 0);
            g = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 11));
            repeat (g) @(negedge clk);
        end
        wait_empty();
        chk("no_stray_total", stray, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
